// File: rtl/load_register.sv
// Parameterised storage register: captures `in` on a rising clock edge when `load`
// is high and otherwise holds its value. Reset forces RESET_VALUE asynchronously.
module load_register #(
  parameter int unsigned          WIDTH       = 32,
  parameter logic [WIDTH-1:0]     RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  // Declaration initialiser gives the power-up value when no reset is applied.
  logic [WIDTH-1:0] out_q = RESET_VALUE;
  logic [WIDTH-1:0] out_d;

  // Next value: capture on load, otherwise hold.
  always_comb begin
    out_d = out_q;
    if (load) begin
      out_d = in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= RESET_VALUE;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_load_register.sv
// Directed bench for load_register: a default 32-bit instance, a 32-bit instance
// with a non-zero reset value, and a 1-bit instance that is never reset.
module tb_load_register;

  localparam logic [31:0] RV_B = 32'hA5A5A5A5;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [31:0] in_w;
  logic [31:0] out_a;
  logic [31:0] out_b;

  logic        rst_n1;
  logic        load1;
  logic        in1;
  logic        out1;

  int unsigned n_tests;
  int unsigned n_fail;

  load_register #(.WIDTH(32)) u_a (
    .clk(clk), .rst_n(rst_n), .load(load), .in(in_w), .out(out_a)
  );

  load_register #(.WIDTH(32), .RESET_VALUE(RV_B)) u_b (
    .clk(clk), .rst_n(rst_n), .load(load), .in(in_w), .out(out_b)
  );

  load_register #(.WIDTH(1)) u_c (
    .clk(clk), .rst_n(rst_n1), .load(load1), .in(in1), .out(out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    load    = 1'b0;
    in_w    = 32'h0;
    rst_n1  = 1'b1;
    load1   = 1'b1;
    in1     = 1'b0;

    // Power-up / reset state before any edge.
    #1;
    check("reset_a", out_a, 32'h0);
    check("reset_b", out_b, RV_B);
    check("powerup_w1", {31'h0, out1}, 32'h0);

    // Reset held across edges ignores load.
    load = 1'b1;
    in_w = 32'h5555AAAA;
    tick();
    check("reset_hold_a", out_a, 32'h0);
    check("reset_hold_b", out_b, RV_B);

    @(negedge clk);
    rst_n = 1'b1;
    in_w  = 32'h12345678;
    tick();
    check("load_a_1234", out_a, 32'h12345678);
    check("load_b_1234", out_b, 32'h12345678);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_a", out_a, 32'h0);
    check("async_rst_b", out_b, RV_B);

    // Release, then load with in toggling before the edge (no bypass).
    @(negedge clk);
    rst_n = 1'b1;
    load  = 1'b1;
    in_w  = 32'h11111111;
    #2;
    check("no_bypass", out_a, 32'h0);
    in_w = 32'hDEADBEEF;
    tick();
    check("load_dead", out_a, 32'hDEADBEEF);

    // Hold for 5 edges with load low.
    load = 1'b0;
    in_w = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold", out_a, 32'hDEADBEEF);
    end

    // Back-to-back loads.
    load = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_w = 32'(i);
      tick();
      check("b2b", out_a, 32'(i));
    end

    // Reset coincident with a loading edge wins.
    @(negedge clk);
    load = 1'b1;
    in_w = 32'hCAFEF00D;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_prio_a", out_a, 32'h0);
    check("rst_prio_b", out_b, RV_B);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("after_rel_a", out_a, 32'hCAFEF00D);
    check("after_rel_b", out_b, 32'hCAFEF00D);

    // 1-bit instance, load tied high: follows in one cycle later.
    check("w1_before", {31'h0, out1}, 32'h0);
    begin
      logic [3:0] pat;
      pat = 4'b0110;
      for (int i = 0; i < 4; i++) begin
        in1 = pat[3 - i];
        #2;
        check("w1_no_bypass", {31'h0, out1}, (i == 0) ? 32'h0 : {31'h0, pat[4 - i]});
        tick();
        check("w1_follow", {31'h0, out1}, {31'h0, pat[3 - i]});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
